// File: rtl/nibble_serial_subtractor.sv
// nibble_serial_subtractor
//
// Multi-cycle unsigned subtractor: Diff = (A - B - B_in) mod 2^WIDTH and
// B_out = 1 iff A < B + B_in. One 4-bit nibble is processed per clock,
// least significant nibble first, with a registered borrow between steps.
//
// Handshake: a request is accepted on any rising edge where start=1 and
// the unit is idle (busy=0); A, B and B_in are captured on that edge and
// are not looked at again. start while busy=1 is dropped, not queued.
// done is a one-cycle pulse; Diff/B_out are valid from that cycle and
// hold until the next operation completes.
//
// Ports:
//   clk       - clock, rising edge
//   rst       - synchronous active-high reset
//   start     - operation request, sampled only while idle
//   A, B      - minuend / subtrahend (WIDTH bits)
//   B_in      - borrow-in
//   busy      - high whenever the FSM is not idle
//   done      - one-cycle completion pulse
//   Diff      - registered difference
//   B_out     - registered borrow-out
//   dbg_state - current FSM state (0=IDLE, 1=RUN, 2=DONE) for observation

module nibble_serial_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             B_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             B_out,
    output logic [1:0]       dbg_state
);

    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] a_sh;     // minuend, shifted right one nibble per step
    logic [WIDTH-1:0] b_sh;     // subtrahend, shifted alongside a_sh
    logic [WIDTH-1:0] res;      // result nibbles shifted in from the top
    logic             borrow;
    logic [CW-1:0]    cnt;

    logic [4:0]       sub;
    logic             last_step;
    logic [WIDTH-1:0] d_ext;
    logic [WIDTH-1:0] res_next;

    // 5-bit subtract of the current low nibbles. Bit 4 is the borrow; the
    // worst case 0 - 15 - 1 = -16 still fits, so the chain cannot overflow.
    always_comb begin
        sub       = {1'b0, a_sh[3:0]} - {1'b0, b_sh[3:0]} - {4'b0000, borrow};
        last_step = (cnt == CW'(NIB - 1));
        d_ext     = '0;
        d_ext[3:0] = sub[3:0];
        // After NIB steps the first nibble computed has reached bit 0.
        res_next  = (res >> 4) | (d_ext << (WIDTH - 4));
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_step) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            res    <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            Diff   <= '0;
            B_out  <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh   <= A;
                        b_sh   <= B;
                        borrow <= B_in;
                        cnt    <= '0;
                        res    <= '0;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 4;
                    b_sh   <= b_sh >> 4;
                    res    <= res_next;
                    borrow <= sub[4];
                    cnt    <= cnt + CW'(1);
                    if (last_step) begin
                        Diff  <= res_next;
                        B_out <= sub[4];
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign dbg_state = state;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
module tb_nibble_serial_subtractor;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] A, B;
    logic             B_in;
    logic             busy, done, B_out;
    logic [WIDTH-1:0] Diff;
    logic [1:0]       dbg_state;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    logic [WIDTH-1:0] prev_diff = '0;
    logic             prev_bo   = 1'b0;

    nibble_serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .A         (A),
        .B         (B),
        .B_in      (B_in),
        .busy      (busy),
        .done      (done),
        .Diff      (Diff),
        .B_out     (B_out),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    always @(posedge clk) if (done === 1'b1) done_cnt++;

    // advance one rising edge and settle
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                         input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- driver ----------------
    // One full operation with cycle-exact handshake checks. If inject is
    // set, a second start with other operands is raised during RUN.
    task automatic run_op(input string tag, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic bin,
                          input logic [WIDTH-1:0] exp_d, input logic exp_bo,
                          input bit inject);
        int dc0;
        dc0   = done_cnt;
        A     = a;
        B     = b;
        B_in  = bin;
        start = 1'b1;
        step();                               // edge 0: accepted
        start = 1'b0;
        A     = ~a;                           // post-capture changes are ignored
        B     = ~b;
        B_in  = ~bin;
        for (int k = 0; k < NIB; k++) begin
            check({tag, "_busy_run"}, WIDTH'(busy), WIDTH'(1));
            check({tag, "_done_run"}, WIDTH'(done), WIDTH'(0));
            check({tag, "_diff_hold"}, Diff, prev_diff);
            if (inject && k == 1) begin
                start = 1'b1;
                A     = 16'hFFFF;
                B     = 16'h0000;
                B_in  = 1'b0;
            end else begin
                start = 1'b0;
            end
            step();                           // edges 1..NIB
        end
        check({tag, "_done"}, WIDTH'(done), WIDTH'(1));
        check({tag, "_diff"}, Diff, exp_d);
        check({tag, "_bout"}, WIDTH'(B_out), WIDTH'(exp_bo));
        step();                               // DONE -> IDLE
        check({tag, "_busy_end"}, WIDTH'(busy), WIDTH'(0));
        check({tag, "_done_end"}, WIDTH'(done), WIDTH'(0));
        check({tag, "_done_count"}, WIDTH'(done_cnt - dc0), WIDTH'(1));
        prev_diff = exp_d;
        prev_bo   = exp_bo;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int dlog[$];
        int guard;
        rst   = 1'b1;
        start = 1'b1;                          // reset must win over start
        A     = 16'hAAAA;
        B     = 16'h5555;
        B_in  = 1'b0;
        step();
        step();
        rst   = 1'b0;
        start = 1'b0;
        step();
        check("rst_busy",  WIDTH'(busy),  WIDTH'(0));
        check("rst_done",  WIDTH'(done),  WIDTH'(0));
        check("rst_diff",  Diff,          16'h0000);
        check("rst_bout",  WIDTH'(B_out), WIDTH'(0));
        check("rst_state", WIDTH'(dbg_state), WIDTH'(0));

        run_op("basic",   16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);
        run_op("ripple",  16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0);
        run_op("wrap",    16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        run_op("maxbin",  16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        run_op("halfbin", 16'h8000, 16'h7FFF, 1'b1, 16'h0000, 1'b0, 1'b0);
        run_op("inject",  16'h00FF, 16'h000F, 1'b0, 16'h00F0, 1'b0, 1'b1);

        // start held high: one operation per NIB+2 cycles
        A     = 16'h0009;
        B     = 16'h0004;
        B_in  = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done === 1'b1) dlog.push_back(i);
        end
        start = 1'b0;
        check("held_count", WIDTH'(dlog.size()), WIDTH'(3));
        if (dlog.size() == 3) begin
            check("held_first", WIDTH'(dlog[0]), WIDTH'(NIB));
            check("held_gap1", WIDTH'(dlog[1] - dlog[0]), WIDTH'(NIB + 2));
            check("held_gap2", WIDTH'(dlog[2] - dlog[1]), WIDTH'(NIB + 2));
        end
        check("held_diff", Diff, 16'h0005);
        guard = 0;
        while (busy === 1'b1 && guard < 20) begin
            step();
            guard++;
        end
        check("held_drain", WIDTH'(busy), WIDTH'(0));
        prev_diff = 16'h0005;

        // reset in the middle of RUN
        A     = 16'h4321;
        B     = 16'h0001;
        start = 1'b1;
        step();                               // edge 0
        start = 1'b0;
        step();                               // edge 1 (RUN k=0)
        check("abort_prev_diff", Diff, 16'h0005);
        rst = 1'b1;
        step();                               // edge 2 with reset
        rst = 1'b0;
        check("abort_busy",  WIDTH'(busy),  WIDTH'(0));
        check("abort_diff",  Diff,          16'h0000);
        check("abort_bout",  WIDTH'(B_out), WIDTH'(0));
        begin
            int dc0;
            dc0 = done_cnt;
            for (int i = 0; i < NIB + 2; i++) step();
            check("abort_no_done", WIDTH'(done_cnt - dc0), WIDTH'(0));
        end
        prev_diff = 16'h0000;
        run_op("post_rst", 16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // absolute time limit so the bench can never hang
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/nibble_serial_subtractor.md
Name: nibble_serial_subtractor

Overview:
Multi-cycle unsigned subtractor, the inverse datapath of the team's combinational 4-bit adder. It computes A - B - Bin over WIDTH bits, one 4-bit nibble per clock, with an internal borrow chain. It uses a start/busy/done handshake. It serves as an area-cheap arithmetic unit in the CADD datapath wherever throughput is not critical.

Parameters:
WIDTH, 16, operand and result width in bits; must be a multiple of 4 and at least 4.
NIB (derived, not overridable), WIDTH/4, number of nibble steps per operation.

Ports:
clk  input  1  single clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
A  input  WIDTH  minuend, captured on accepted start
B  input  WIDTH  subtrahend, captured on accepted start
B_in  input  1  borrow-in, captured on accepted start
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse; Diff/B_out valid from this cycle on
Diff  output  WIDTH  registered result (A - B - B_in) mod 2^WIDTH
B_out  output  1  registered borrow-out: 1 iff A < B + B_in (unsigned)

Behaviour:
- Reset (rst=1 at edge): state=IDLE; busy=0, done=0, Diff=0, B_out=0; internal operand regs, nibble counter and borrow cleared. Reset overrides every other input, including a start in the same cycle.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge: latch A, B, B_in into working regs; borrow:=B_in; counter:=0; go to RUN.
  - start=0: stay in IDLE; outputs hold.
- RUN, edge k (k=0..NIB-1):
  - {borrow_next, d} = A_nib[k] - B_nib[k] - borrow, computed as a 5-bit op; d is 4 bits, borrow_next=1 on underflow.
  - d written to working result nibble k; borrow:=borrow_next; counter++.
  - At k=NIB-1: Diff:=full working result, B_out:=final borrow, go to DONE.
- DONE: done=1 for exactly this one cycle; next edge goes to IDLE.
- Latency and throughput:
  - start accepted at edge 0; done high in the cycle after edge NIB.
  - Next start is accepted at edge NIB+2 at the earliest.
  - A start held high continuously gives one operation per NIB+2 cycles.
- start while busy (RUN or DONE): ignored, no queuing. Input changes after capture do not affect the operation in flight.
- Diff/B_out change only on the RUN→DONE transition. While a new operation runs, they keep showing the previous result.
- Reset mid-operation: abort immediately, no done pulse, outputs cleared to 0.
- Wrap-around: the result is modulo 2^WIDTH, never saturated. Borrow propagates across nibble boundaries exactly as a full-width subtraction would.
- B_in=1 with B=2^WIDTH-1: the borrow chain must not overflow; the result is A mod 2^WIDTH with B_out=1.

Test Plan:
- rst held 2 cycles, then released with start=0 -> busy=0, done=0, Diff=0x0000, B_out=0; state remains IDLE.
- A=0x1234, B=0x0234, B_in=0, start pulsed at edge 0 -> busy high edges 0..5; done pulse in the cycle after edge 4; Diff=0x1000, B_out=0.
- A=0x1000, B=0x0001, B_in=0 -> Diff=0x0FFF, B_out=0; the borrow ripples through 3 nibbles. Then A=0x0000, B=0x0001 -> Diff=0xFFFF, B_out=1.
- A=0xFFFF, B=0xFFFF, B_in=1 -> Diff=0xFFFF, B_out=1. A=0x8000, B=0x7FFF, B_in=1 -> Diff=0x0000, B_out=0.
- Second start pulsed during RUN with different operands -> ignored; only one done; result matches the first operands. start held high for 20 cycles -> done pulses 6 cycles apart.
- rst asserted at RUN edge 2 -> next cycle busy=0, Diff=0, B_out=0; no done pulse. A following operation 0x0005-0x0003 -> Diff=0x0002, B_out=0.
